// File: rtl/calc_pkg.sv
// Shared definitions for the calc_responder slice.
// Contents: FSM state type (RX_A..TX_Z, plus TX_CHK when the checksum word
// is enabled), state width, response length, and a TX-state helper.
// Optional feature macro: CALC_CHECKSUM_EN (appends TX_CHK, 5-word response).
package calc_pkg;

    localparam int unsigned STATE_W = 4;

`ifdef CALC_CHECKSUM_EN
    localparam int unsigned RESP_LEN = 5;
`else
    localparam int unsigned RESP_LEN = 4;
`endif

    typedef enum logic [STATE_W-1:0] {
        RX_A,
        RX_B,
        RX_C,
        CALC,
        TX_W,
        TX_X,
        TX_Y,
        TX_Z
`ifdef CALC_CHECKSUM_EN
        , TX_CHK
`endif
    } state_t;

    // True in every state that presents a result word downstream.
    function automatic logic is_tx(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            TX_W, TX_X, TX_Y, TX_Z: r = 1'b1;
`ifdef CALC_CHECKSUM_EN
            TX_CHK:                 r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Purely combinational four-result calculation, all results modulo 2**WIDTH.
// Ports:
//   a, b, c  in   WIDTH  operands
//   w        out  WIDTH  (b + c) | a
//   x        out  WIDTH  (a & c) + b
//   y        out  WIDTH  (~a + c) & b
//   z        out  WIDTH  (b | c) & a
module calc_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    logic [WIDTH-1:0] sum_bc;
    logic [WIDTH-1:0] and_ac;
    logic [WIDTH-1:0] sum_na_c;

    always_comb begin
        // Intermediate sums are held at WIDTH bits so carries are dropped.
        sum_bc   = b + c;
        and_ac   = a & c;
        sum_na_c = ~a + c;
        w        = sum_bc | a;
        x        = and_ac + b;
        y        = sum_na_c & b;
        z        = (b | c) & a;
    end

endmodule

// File: rtl/calc_responder.sv
// Byte-serial responder: accepts operands a, b, c on a valid/ready input
// stream, computes w, x, y, z via calc_alu, and returns them in order on a
// valid/ready output stream.
// Optional feature macro: CALC_CHECKSUM_EN -- appends a fifth word w^x^y^z.
// Ports:
//   clk        in   1      clock, posedge
//   rst_n      in   1      synchronous reset, active-low
//   in_data    in   WIDTH  operand word (a, b, c)
//   in_valid   in   1      in_data valid
//   in_ready   out  1      operand word can be accepted (RX states)
//   out_data   out  WIDTH  result word (w, x, y, z[, chk]); 0 when idle
//   out_valid  out  1      out_data valid (TX states)
//   out_ready  in   1      downstream accepts out_data
//   busy       out  1      high in any state other than RX_A
module calc_responder
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [WIDTH-1:0] w_q, x_q, y_q, z_q;
    logic [WIDTH-1:0] alu_w, alu_x, alu_y, alu_z;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    calc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a (a_q),
        .b (b_q),
        .c (c_q),
        .w (alu_w),
        .x (alu_x),
        .y (alu_y),
        .z (alu_z)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RX_A;
        end else begin
            state <= state_next;
        end
    end

    // Operand and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            w_q <= '0;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            if (in_fire) begin
                case (state)
                    RX_A:    a_q <= in_data;
                    RX_B:    b_q <= in_data;
                    RX_C:    c_q <= in_data;
                    default: ;
                endcase
            end
            if (state == CALC) begin
                w_q <= alu_w;
                x_q <= alu_x;
                y_q <= alu_y;
                z_q <= alu_z;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RX_A: if (in_fire)  state_next = RX_B;
            RX_B: if (in_fire)  state_next = RX_C;
            RX_C: if (in_fire)  state_next = CALC;
            CALC:               state_next = TX_W;
            TX_W: if (out_fire) state_next = TX_X;
            TX_X: if (out_fire) state_next = TX_Y;
            TX_Y: if (out_fire) state_next = TX_Z;
`ifdef CALC_CHECKSUM_EN
            TX_Z: if (out_fire) state_next = TX_CHK;
            TX_CHK: if (out_fire) state_next = RX_A;
`else
            TX_Z: if (out_fire) state_next = RX_A;
`endif
            default:            state_next = RX_A;
        endcase
    end

    // Output logic: handshakes and result mux are pure functions of state,
    // so out_data/out_valid cannot change while stalled.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = is_tx(state);
        out_data  = '0;
        busy      = (state != RX_A);
        case (state)
            RX_A, RX_B, RX_C: in_ready = 1'b1;
            TX_W:             out_data = w_q;
            TX_X:             out_data = x_q;
            TX_Y:             out_data = y_q;
            TX_Z:             out_data = z_q;
`ifdef CALC_CHECKSUM_EN
            TX_CHK:           out_data = w_q ^ x_q ^ y_q ^ z_q;
`endif
            default:          ;
        endcase
    end

endmodule

// File: tb/tb_calc_responder.sv
// Self-checking bench for calc_responder: directed scenarios followed by
// randomized transactions, checked against an arithmetic reference model.
// Honours CALC_CHECKSUM_EN the same way as the design.
module tb_calc_responder;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    logic [7:0] exp_q[$];

    calc_responder #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic rules, modulo 256.
    function automatic void model(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned w, x, y, z;
        w = ((b + c) % 256) | a;
        x = ((a & c) + b) % 256;
        y = (((255 - a) + c) % 256) & b;
        z = (b | c) & a;
        exp_q.delete();
        exp_q.push_back(8'(w));
        exp_q.push_back(8'(x));
        exp_q.push_back(8'(y));
        exp_q.push_back(8'(z));
`ifdef CALC_CHECKSUM_EN
        exp_q.push_back(8'(w ^ x ^ y ^ z));
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [7:0] d, input string tag);
        int i;
        in_data  = d;
        in_valid = 1'b1;
        i = 0;
        while (!in_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drains one response; stalls each word lo..hi cycles while wiggling in_valid.
    task automatic recv_resp(input int unsigned lo, input int unsigned hi,
                             input logic hold_valid, input string tag);
        int i;
        int unsigned stall;
        for (int unsigned k = 0; k < RESP_LEN; k++) begin
            out_ready = 1'b0;
            i = 0;
            while (!out_valid && i < 20) begin
                @(negedge clk);
                i++;
            end
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(exp_q[k]));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            stall = $urandom_range(hi, lo);
            for (int unsigned s = 0; s < stall; s++) begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = 8'($urandom);
                @(negedge clk);
                check({tag, "_stall_data"}, 32'(out_data), 32'(exp_q[k]));
                check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = hold_valid;
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input int unsigned lo, input int unsigned hi,
                           input logic hold_valid, input string tag);
        model(a, b, c);
        send_word(a, {tag, "_a"});
        send_word(b, {tag, "_b"});
        send_word(c, {tag, "_c"});
        // One cycle of CALC, then the first word appears.
        check({tag, "_calc_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_calc_in_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
        recv_resp(lo, hi, hold_valid, tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal and wrap-around vectors
        run_txn(8'hFF, 8'h3F, 8'h1D, 0, 0, 1'b0, "nominal");
        run_txn(8'h0F, 8'hF0, 8'h20, 0, 0, 1'b0, "wrap");

        // Back-pressure: three stall cycles on every word
        run_txn(8'hFF, 8'h3F, 8'h1D, 3, 3, 1'b0, "bp");

        // Reset after b is accepted, then an all-zero transaction
        send_word(8'h5A, "rstmid_a");
        send_word(8'hA5, "rstmid_b");
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        run_txn(8'h00, 8'h00, 8'h00, 0, 1, 1'b0, "rstmid");

        // Back-to-back with in_valid held high across the turnaround
        run_txn(8'h12, 8'h34, 8'h56, 0, 0, 1'b1, "b2b1");
        run_txn(8'h9A, 8'hBC, 8'hDE, 0, 0, 1'b1, "b2b2");
        in_valid = 1'b0;

        // Randomized transactions with random stalls and idle-stream noise
        for (int t = 0; t < 20; t++) begin
            run_txn(8'($urandom), 8'($urandom), 8'($urandom), 0, 2,
                    1'($urandom_range(1, 0)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
